lane_scan_renderer: RTL and testbench

LANE_SCAN_RENDERER -- requirements
Module: lane_scan_renderer

---
 rtl/lane_scan_renderer.sv | 171 +++++++++++++++++
 tb/tb_lane_scan_renderer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_scan_renderer.sv
// Lane scan renderer: once per frame, walks every lane, erasing the segment drawn
// last frame and then drawing the new one, one pixel per clock.
module lane_scan_renderer #(
   parameter int         NUM_LANES  = 4,
   parameter int         NUM_COLS   = 4,
   parameter int         LANE_PITCH = 40,
   parameter int         X_BASE     = 120,
   parameter int         SEG_WIDTH  = 20,
   parameter int         Y_MAX      = 240,
   parameter logic [2:0] DRAW_COLOR = 3'b111
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [3*NUM_LANES-1:0] lane_pos,
   input  logic [5:0]             offset,
   output logic [8:0]             x_out,
   output logic [7:0]             y_out,
   output logic [2:0]             c_out,
   output logic                   plot,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             state_dbg
);

   // Request protocol: start is taken only while busy=0 (IDLE); a start seen
   // while busy=1 is dropped, and done pulses for one cycle when the frame ends.
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_ERASE = 3'd2;
   localparam logic [2:0] S_DRAW  = 3'd3;
   localparam logic [2:0] S_NEXT  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [2:0] LAST_LANE = 3'(NUM_LANES - 1);
   localparam logic [8:0] LAST_PX   = 9'(SEG_WIDTH - 1);

   logic [2:0]             state, nstate;
   logic [2:0]             lane, nlane, el;
   logic [8:0]             px, npx;
   logic [3*NUM_LANES-1:0] cur_pos, prev_pos;
   logic [5:0]             cur_offset, prev_offset;
   logic [2:0]             ep, ec, pcode;
   logic                   ep_ok, ec_ok;
   logic [5:0]             poff;
   logic [8:0]             y9, x9;
   logic                   on_screen;

   function automatic logic code_ok(input logic [2:0] c);
      return (c != 3'd0) && (int'(c) <= NUM_COLS);
   endfunction

   // Lane whose codes decide the next phase: LOAD enters lane 0, NEXT enters lane+1.
   always_comb begin
      el = lane;
      if (state == S_LOAD)
         el = 3'd0;
      else if (state == S_NEXT && lane != LAST_LANE)
         el = lane + 3'd1;
   end

   always_comb begin
      ep = 3'd0;
      ec = 3'd0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (int'(el) == i) begin
            ep = prev_pos[3*i +: 3];
            ec = cur_pos[3*i +: 3];
         end
      end
   end

   assign ep_ok = code_ok(ep);
   assign ec_ok = code_ok(ec);

   always_comb begin
      nstate = state;
      nlane  = lane;
      npx    = px;
      case (state)
         S_IDLE: begin
            if (start)
               nstate = S_LOAD;
         end
         S_LOAD, S_NEXT: begin
            npx = 9'd0;
            if (state == S_NEXT && lane == LAST_LANE) begin
               nstate = S_DONE;
            end else begin
               // Phases with an empty or out-of-range code are skipped outright.
               nlane = el;
               if (ep_ok)
                  nstate = S_ERASE;
               else if (ec_ok)
                  nstate = S_DRAW;
               else
                  nstate = S_NEXT;
            end
         end
         S_ERASE: begin
            if (px == LAST_PX) begin
               npx    = 9'd0;
               nstate = ec_ok ? S_DRAW : S_NEXT;
            end else begin
               npx = px + 9'd1;
            end
         end
         S_DRAW: begin
            if (px == LAST_PX) begin
               npx    = 9'd0;
               nstate = S_NEXT;
            end else begin
               npx = px + 9'd1;
            end
         end
         S_DONE:  nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
   end

   // Pixel for the upcoming cycle, so the registered outputs line up with the state.
   assign pcode     = (nstate == S_ERASE) ? ep : ec;
   assign poff      = (nstate == S_ERASE) ? prev_offset : cur_offset;
   assign y9        = 9'(int'(nlane) * LANE_PITCH + int'(poff));
   assign x9        = 9'(X_BASE + (int'(pcode) - 1) * SEG_WIDTH + int'(npx));
   assign on_screen = int'(y9) < Y_MAX;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         lane        <= 3'd0;
         px          <= 9'd0;
         x_out       <= 9'd0;
         y_out       <= 8'd0;
         c_out       <= 3'd0;
         plot        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cur_pos     <= '0;
         cur_offset  <= 6'd0;
         prev_pos    <= '0;
         prev_offset <= 6'd0;
      end else begin
         state <= nstate;
         lane  <= nlane;
         px    <= npx;
         busy  <= (nstate != S_IDLE);
         done  <= (nstate == S_DONE);
         if (nstate == S_ERASE || nstate == S_DRAW) begin
            x_out <= x9;
            y_out <= y9[7:0];
            c_out <= (nstate == S_ERASE) ? 3'b000 : DRAW_COLOR;
            plot  <= on_screen;
         end else begin
            plot <= 1'b0;
         end
         if (state == S_IDLE && start) begin
            cur_pos    <= lane_pos;
            cur_offset <= offset;
         end
         // Only a frame that reaches DONE becomes next frame's erase reference.
         if (state == S_DONE) begin
            prev_pos    <= cur_pos;
            prev_offset <= cur_offset;
         end
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_lane_scan_renderer.sv
// Bench for lane_scan_renderer: fixed frame table, start-held and abort sequences,
// then random frames checked pixel by pixel against a frame-level reference model.
module tb_lane_scan_renderer;

   localparam int NL = 6;
   localparam int W  = 20;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [3*NL-1:0] lane_pos;
   logic [5:0]    offset;
   logic [8:0]    x_out;
   logic [7:0]    y_out;
   logic [2:0]    c_out;
   logic          plot;
   logic          busy;
   logic          done;
   logic [2:0]    state_dbg;

   lane_scan_renderer #(.NUM_LANES(NL)) dut (
      .clk(clk), .reset(reset), .start(start), .lane_pos(lane_pos), .offset(offset),
      .x_out(x_out), .y_out(y_out), .c_out(c_out), .plot(plot), .busy(busy),
      .done(done), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];
   int exp_done;
   int model_prev[NL];
   int model_prev_off;

   typedef struct {
      logic [3*NL-1:0] pos;
      logic [5:0]      off;
      int              exp_done;
      int              exp_plots;
      logic [W-1:0]    first;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   function automatic logic [W-1:0] pix(input int x, input int y, input int c);
      return {9'(x), 8'(y), 3'(c)};
   endfunction

   // Reference model: each lane erases its old segment, then draws its new one.
   task automatic model_build(input logic [3*NL-1:0] pos, input int off);
      int phases;
      phases = 0;
      exp_q.delete();
      for (int l = 0; l < NL; l++) begin
         int pc, cc, y;
         pc = model_prev[l];
         cc = int'(pos[3*l +: 3]);
         if (pc >= 1 && pc <= 4) begin
            phases++;
            y = l * 40 + model_prev_off;
            if (y < 240)
               for (int i = 0; i < 20; i++) exp_q.push_back(pix(120 + (pc - 1) * 20 + i, y, 0));
         end
         if (cc >= 1 && cc <= 4) begin
            phases++;
            y = l * 40 + off;
            if (y < 240)
               for (int i = 0; i < 20; i++) exp_q.push_back(pix(120 + (cc - 1) * 20 + i, y, 7));
         end
      end
      exp_done = 2 + NL + 20 * phases;
   endtask

   task automatic model_commit(input logic [3*NL-1:0] pos, input int off);
      for (int l = 0; l < NL; l++) model_prev[l] = int'(pos[3*l +: 3]);
      model_prev_off = off;
   endtask

   task automatic model_reset();
      for (int l = 0; l < NL; l++) model_prev[l] = 0;
      model_prev_off = 0;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      start    = 1'b0;
      lane_pos = '0;
      offset   = 6'd0;
      repeat (3) @(negedge clk);
      check("rst_x", x_out, 0);
      check("rst_y", y_out, 0);
      check("rst_c", c_out, 0);
      check("rst_plot", plot, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      model_reset();
   endtask

   // Runs one frame; cycle k=0 is the cycle in which start is sampled in IDLE.
   task automatic run_frame(input logic [3*NL-1:0] pos, input logic [5:0] off,
                            input bit chaos, input bit keep_start, input bit preloaded,
                            input int abort_k, output int got_done, output int got_plots,
                            output logic [W-1:0] got_first);
      int k;
      bit fin;
      model_build(pos, int'(off));
      got_done  = -1;
      got_plots = 0;
      got_first = '0;
      if (!preloaded) begin
         @(negedge clk);
         lane_pos = pos;
         offset   = off;
         start    = 1'b1;
         @(negedge clk);
      end
      k   = 1;
      fin = 0;
      check("load_busy", busy, 1);
      while (!fin) begin
         if (plot) begin
            got_plots++;
            if (got_plots == 1) got_first = {x_out, y_out, c_out};
            if (exp_q.size() == 0) check("extra_plot", plot, 0);
            else check("pixel", {x_out, y_out, c_out}, exp_q.pop_front());
         end
         if (abort_k != 0 && k == abort_k) begin
            reset = 1'b1;
            start = 1'b0;
            @(negedge clk);
            check("abort_x", x_out, 0);
            check("abort_y", y_out, 0);
            check("abort_c", c_out, 0);
            check("abort_plot", plot, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            reset = 1'b0;
            exp_q.delete();
            model_reset();
            return;
         end
         if (done) begin
            got_done = k;
            fin = 1;
         end else if (k >= exp_done + 20) begin
            check("frame_timeout", done, 1);
            fin = 1;
         end
         if (keep_start)
            start = 1'b1;
         else if (!fin && chaos && k + 1 < exp_done)
            start = 1'($urandom_range(0, 1));
         else
            start = 1'b0;
         if (!fin && chaos && k >= 2) begin
            lane_pos = 18'($urandom);
            offset   = 6'($urandom);
         end
         if (!fin) begin
            @(negedge clk);
            k++;
         end
      end
      check("done_cycle", got_done, exp_done);
      check("queue_empty", exp_q.size(), 0);
      if (got_done > 0) model_commit(pos, int'(off));
   endtask

   initial begin
      int d, p;
      logic [W-1:0] f;
      logic [3*NL-1:0] rpos;

      vecs[0] = '{18'o000001, 6'd5,  28,  20, pix(120, 5, 7)};
      vecs[1] = '{18'o000021, 6'd6,  68,  60, pix(120, 5, 0)};
      vecs[2] = '{18'o000037, 6'd0,  68,  60, pix(120, 6, 0)};
      vecs[3] = '{18'o444444, 6'd63, 148, 120, pix(180, 63, 7)};
      vecs[4] = '{18'o000000, 6'd0,  128, 100, pix(180, 63, 0)};
      vecs[5] = '{18'o000000, 6'd0,  8,   0,   '0};

      do_reset();

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].pos, vecs[i].off, 0, 0, 0, 0, d, p, f);
         check($sformatf("vec%0d_done", i), d, vecs[i].exp_done);
         check($sformatf("vec%0d_plots", i), p, vecs[i].exp_plots);
         if (vecs[i].exp_plots > 0) check($sformatf("vec%0d_first", i), f, vecs[i].first);
      end

      // start held high: one IDLE cycle after DONE, then the next LOAD
      run_frame(18'o000102, 6'd10, 0, 1, 0, 0, d, p, f);
      @(negedge clk);
      check("gap_busy", busy, 0);
      check("gap_done", done, 0);
      check("gap_plot", plot, 0);
      @(negedge clk);
      check("reload_busy", busy, 1);
      run_frame(18'o000102, 6'd10, 0, 0, 1, 0, d, p, f);
      check("held_second_first", f, pix(140, 10, 0));

      // reset in the middle of lane 0's DRAW phase, then a fresh frame
      run_frame(18'o000003, 6'd0, 0, 0, 0, 30, d, p, f);
      run_frame(18'o000001, 6'd1, 0, 0, 0, 0, d, p, f);
      check("post_abort_done", d, 28);
      check("post_abort_plots", p, 20);
      check("post_abort_first", f, pix(120, 1, 7));

      for (int n = 0; n < 15; n++) begin
         for (int l = 0; l < NL; l++) rpos[3*l +: 3] = 3'($urandom_range(0, 7));
         run_frame(rpos, 6'($urandom_range(0, 63)), 1, 0, 0, 0, d, p, f);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
